// File: rtl/mc_bram_port.sv
// rtl/mc_bram_port.sv - memory-side endpoint for MemCont
// Single-cycle-latency RAM with post-reset clear, sticky error flags and access counters.
module mc_bram_port #(
  parameter int DATA_SIZE      = 32,
  parameter int ADDRESS_SIZE   = 32,
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    io_loadEnable,
  input  logic [ADDRESS_SIZE-1:0] io_loadAddrOut,
  output logic [DATA_SIZE-1:0]    io_loadDataIn,
  input  logic                    io_storeEnable,
  input  logic [ADDRESS_SIZE-1:0] io_storeAddrOut,
  input  logic [DATA_SIZE-1:0]    io_storeDataOut,
  output logic                    busy,
  output logic                    err_load,
  output logic                    err_store,
  output logic [31:0]             load_count,
  output logic [31:0]             store_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS_SIZE:0] DEPTH_EXT = (ADDRESS_SIZE + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  localparam logic [0:0] RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [0:0]           state;
  logic [PW-1:0]        ptr;

  logic          ready;
  logic          load_ok, load_bad, store_ok, store_bad, same_addr;
  logic [PW-1:0] load_idx, store_idx;

  // Range check uses the full address width plus one guard bit, so no high bits are dropped.
  always_comb begin
    ready     = (state == READY);
    load_ok   = io_loadEnable && ready && ({1'b0, io_loadAddrOut} < DEPTH_EXT);
    load_bad  = io_loadEnable && !load_ok;
    store_ok  = io_storeEnable && ready && ({1'b0, io_storeAddrOut} < DEPTH_EXT);
    store_bad = io_storeEnable && !store_ok;
    load_idx  = io_loadAddrOut[PW-1:0];
    store_idx = io_storeAddrOut[PW-1:0];
    same_addr = (io_loadAddrOut == io_storeAddrOut);
    busy      = !ready;
  end

  // RAM array has no reset; the clear sequence owns the write port while busy.
  always_ff @(posedge clk) begin
    if (!ready && !rst) begin
      mem[ptr] <= '0;
    end else if (store_ok) begin
      mem[store_idx] <= io_storeDataOut;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RESET_STATE;
      ptr           <= '0;
      io_loadDataIn <= '0;
      err_load      <= 1'b0;
      err_store     <= 1'b0;
      load_count    <= '0;
      store_count   <= '0;
    end else begin
      if (state == CLEAR) begin
        ptr <= ptr + 1'b1;
        if (ptr == LAST_PTR) begin
          state <= READY;
        end
      end

      // Write-first: a same-cycle store to the loaded word forwards its data.
      if (load_ok) begin
        io_loadDataIn <= (store_ok && same_addr) ? io_storeDataOut : mem[load_idx];
        if (load_count != 32'hFFFF_FFFF) begin
          load_count <= load_count + 32'd1;
        end
      end else if (load_bad) begin
        io_loadDataIn <= '0;
        err_load      <= 1'b1;
      end

      if (store_ok) begin
        if (store_count != 32'hFFFF_FFFF) begin
          store_count <= store_count + 32'd1;
        end
      end else if (store_bad) begin
        err_store <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_bram_port.sv
// tb/tb_mc_bram_port.sv - self-checking bench for mc_bram_port
// Directed scenarios plus a randomized run against an array-based reference model.
module tb_mc_bram_port;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data;
  logic        store_en = 1'b0;
  logic [31:0] store_addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, err_load, err_store;
  logic [31:0] load_count, store_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mc_bram_port #(
    .DATA_SIZE(32), .ADDRESS_SIZE(32), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_loadEnable(load_en),
    .io_loadAddrOut(load_addr),
    .io_loadDataIn(load_data),
    .io_storeEnable(store_en),
    .io_storeAddrOut(store_addr),
    .io_storeDataOut(store_data),
    .busy(busy),
    .err_load(err_load),
    .err_store(err_store),
    .load_count(load_count),
    .store_count(store_count)
  );

  task automatic idle();
    load_en  = 1'b0;
    store_en = 1'b0;
  endtask

  // Counts sampled cycles with busy high after release, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    int n;
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    checks++;
    if (n !== DEPTH) begin
      fails++;
      $display("FAIL reset_clear_len: got %0d cycles, expected %0d", n, DEPTH);
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, err_load, err_store, load_data, load_count, store_count} !== {3'b100, 96'd0}) begin
      fails++;
      $display("FAIL reset_values: busy=%b el=%b es=%b data=%h lc=%h sc=%h", busy, err_load, err_store,
               load_data, load_count, store_count);
    end
    rst = 1'b0;
    count_busy(n);
    checks++;
    if (n !== DEPTH) begin
      fails++;
      $display("FAIL busy_length: got %0d, expected %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1'b1;
      load_addr = i;
      @(negedge clk);
      checks++;
      if (load_data !== 32'd0) begin
        fails++;
        $display("FAIL cleared_word[%0d]: got %h, expected 0", i, load_data);
      end
    end
    idle();
    checks++;
    if (load_count !== 32'd16) begin
      fails++;
      $display("FAIL reset_load_count: got %0d, expected 16", load_count);
    end
  endtask

  task automatic test_store_load();
    do_reset();
    store_en = 1'b1; store_addr = 5; store_data = 32'hDEADBEEF;
    @(negedge clk);
    store_en = 1'b0; load_en = 1'b1; load_addr = 5;
    @(negedge clk);
    idle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (load_data !== 32'hDEADBEEF) begin
        fails++;
        $display("FAIL load_hold[%0d]: got %h, expected deadbeef", i, load_data);
      end
      @(negedge clk);
    end
    checks++;
    if (store_count !== 32'd1 || load_count !== 32'd1) begin
      fails++;
      $display("FAIL basic_counts: sc=%0d lc=%0d, expected 1 1", store_count, load_count);
    end
  endtask

  task automatic test_same_cycle();
    store_en = 1'b1; store_addr = 3; store_data = 32'h12345678;
    load_en = 1'b1; load_addr = 3;
    @(negedge clk);
    checks++;
    if (load_data !== 32'h12345678) begin
      fails++;
      $display("FAIL write_first: got %h, expected 12345678", load_data);
    end
    store_addr = 4; store_data = 32'hAAAA5555;
    @(negedge clk);
    checks++;
    if (load_data !== 32'h12345678) begin
      fails++;
      $display("FAIL independent_load: got %h, expected 12345678", load_data);
    end
    store_en = 1'b0; load_addr = 4;
    @(negedge clk);
    idle();
    checks++;
    if (load_data !== 32'hAAAA5555) begin
      fails++;
      $display("FAIL independent_store: got %h, expected aaaa5555", load_data);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    store_en = 1'b1; store_addr = 0; store_data = 32'h0BADF00D;
    @(negedge clk);
    store_en = 1'b0; load_en = 1'b1; load_addr = 0;
    @(negedge clk);
    load_addr = 16;
    store_en = 1'b1; store_addr = 32'h8000_0000; store_data = 32'hFFFFFFFF;
    @(negedge clk);
    idle();
    checks++;
    if ({load_data, err_load, err_store, load_count, store_count} !== {32'd0, 2'b11, 32'd1, 32'd1}) begin
      fails++;
      $display("FAIL illegal_access: data=%h el=%b es=%b lc=%0d sc=%0d, expected 0 1 1 1 1",
               load_data, err_load, err_store, load_count, store_count);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({err_load, err_store} !== 2'b11) begin
        fails++;
        $display("FAIL sticky_flags[%0d]: got %b, expected 11", i, {err_load, err_store});
      end
    end
    load_en = 1'b1; load_addr = 0;
    @(negedge clk);
    idle();
    checks++;
    if (load_data !== 32'h0BADF00D) begin
      fails++;
      $display("FAIL ram_untouched: got %h, expected 0badf00d", load_data);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({err_load, err_store} !== 2'b00) begin
      fails++;
      $display("FAIL flags_reset: got %b, expected 00", {err_load, err_store});
    end
  endtask

  task automatic test_clear_store();
    int n;
    do_reset();
    store_en = 1'b1; store_addr = 2; store_data = 32'h5A5A5A5A;
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    store_en = 1'b1; store_addr = 2; store_data = 32'h00000077;
    @(negedge clk);
    idle();
    checks++;
    if (err_store !== 1'b1 || store_count !== 32'd0) begin
      fails++;
      $display("FAIL store_during_clear: es=%b sc=%0d, expected 1 0", err_store, store_count);
    end
    count_busy(n);
    load_en = 1'b1; load_addr = 2;
    @(negedge clk);
    idle();
    checks++;
    if (load_data !== 32'd0) begin
      fails++;
      $display("FAIL clear_wins: got %h, expected 0", load_data);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    checks++;
    if (n !== DEPTH) begin
      fails++;
      $display("FAIL clear_restart: busy %0d cycles, expected %0d", n, DEPTH);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    force dut.load_count = 32'hFFFFFFFE;
    #1;
    release dut.load_count;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      load_en = 1'b1; load_addr = i;
      @(negedge clk);
      checks++;
      if (load_count !== 32'hFFFFFFFF) begin
        fails++;
        $display("FAIL saturate[%0d]: got %h, expected ffffffff", i, load_count);
      end
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] model [DEPTH];
    logic [31:0] exp_data = '0;
    logic [31:0] exp_lc = '0, exp_sc = '0;
    logic        exp_el = 1'b0, exp_es = 1'b0;
    do_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int it = 0; it < 400; it++) begin
      load_en    = ($urandom_range(0, 2) != 0);
      store_en   = ($urandom_range(0, 2) != 0);
      load_addr  = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h10) : 32'($urandom_range(0, 17));
      store_addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h10) : 32'($urandom_range(0, 17));
      if ($urandom_range(0, 3) == 0) store_addr = load_addr;
      store_data = $urandom;
      @(negedge clk);
      if (store_en) begin
        if (store_addr < DEPTH) begin
          model[store_addr] = store_data;
          exp_sc++;
        end else exp_es = 1'b1;
      end
      if (load_en) begin
        if (load_addr < DEPTH) begin
          exp_data = model[load_addr];
          exp_lc++;
        end else begin
          exp_data = '0;
          exp_el = 1'b1;
        end
      end
      checks++;
      if ({load_data, load_count, store_count, err_load, err_store} !== {exp_data, exp_lc, exp_sc, exp_el, exp_es}) begin
        fails++;
        $display("FAIL random[%0d]: data=%h lc=%0d sc=%0d el=%b es=%b, expected %h %0d %0d %b %b", it,
                 load_data, load_count, store_count, err_load, err_store, exp_data, exp_lc, exp_sc, exp_el, exp_es);
      end
    end
    idle();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_store_load();
    test_same_cycle();
    test_illegal();
    test_clear_store();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mc_bram_port.md
Name: mc_bram_port

Overview:
- Memory-side endpoint for MemCont. Consumes its load/store pin group (loadEnable/loadAddrOut, storeEnable/storeAddrOut/storeDataOut) and returns loadDataIn with fixed one-cycle latency.
- On-chip dual-access RAM (one read port, one write port) with an optional post-reset clear sequence.
- Detects illegal accesses (out of range, or issued during clear) and sets sticky error flags.
- Provides saturating access counters for debug and verification.

Parameters:
DATA_SIZE, 32, data word width
ADDRESS_SIZE, 32, address width as produced by MemCont
DEPTH, 1024, number of words; valid addresses 0..DEPTH-1
CLEAR_ON_RESET, 1, 1 = zero every word after reset, 0 = contents untouched by reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
io_loadEnable  in  1  load request this cycle
io_loadAddrOut  in  ADDRESS_SIZE  load word address
io_loadDataIn  out  DATA_SIZE  load data, valid the cycle after the request
io_storeEnable  in  1  store request this cycle
io_storeAddrOut  in  ADDRESS_SIZE  store word address
io_storeDataOut  in  DATA_SIZE  store data
busy  out  1  high while the clear sequence runs
err_load  out  1  sticky: illegal load seen
err_store  out  1  sticky: illegal store seen
load_count  out  32  accepted in-range loads, saturating
store_count  out  32  accepted in-range stores, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: io_loadDataIn=0, err_load=0, err_store=0, load_count=0, store_count=0, clear pointer=0.
  - busy=1 while rst is asserted if CLEAR_ON_RESET=1, else 0.
  - RAM contents are never reset asynchronously.
- FSM states: CLEAR, READY.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
  - CLEAR: write 0 to word[ptr] each cycle and increment ptr. On the cycle writing DEPTH-1, transition to READY the next edge. Clear takes exactly DEPTH cycles after reset release. busy=1 throughout CLEAR.
  - READY: normal operation; busy=0.
  - Reset asserted mid-clear: ptr returns to 0 and the clear restarts in full after release.
- Access legality: an address is in range when it is less than DEPTH, compared over the full ADDRESS_SIZE bits with no truncation. RAM index is addr mod DEPTH, used only when the address is in range.
- Load, in READY and in range:
  - Request at edge N: io_loadDataIn = word[addr] from edge N+1.
  - The value is held stable until the next accepted or illegal load; MemCont may sample it late.
  - load_count increments.
- Store, in READY and in range: word[addr] is written at the edge; store_count increments.
- Illegal load (out of range, or during CLEAR): io_loadDataIn=0 from the next cycle; err_load set; counter unchanged.
- Illegal store (out of range, or during CLEAR): no RAM write; err_store set; counter unchanged. During CLEAR, the clear write always wins.
- Same-cycle load and store, same in-range address: write-first. io_loadDataIn next cycle equals the new store data.
- Same-cycle load and store, different addresses: independent; both complete.
- Sticky flags clear only on reset.
- Counters stop at 32'hFFFFFFFF and never wrap.
- No backpressure exists. Every request is consumed the cycle it is asserted, as MemCont requires.
- Inputs are don't-care when their enable is low. io_loadDataIn does not change without a load.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, DEPTH=16 -> busy high exactly 16 cycles, then 0; loads of addrs 0..15 all return 0; load_count=16.
- Store 0xDEADBEEF to addr 5, then load addr 5 next cycle -> io_loadDataIn=0xDEADBEEF one cycle after the load and held for 3 idle cycles; store_count=1, load_count=1.
- Same cycle: store 0x12345678 to addr 3 and load addr 3 -> next-cycle data 0x12345678. Same cycle: store addr 4, load addr 3 -> 0x12345678.
- Load addr 16 and store addr 0x80000000 with DEPTH=16 -> io_loadDataIn=0, err_load=1, err_store=1, RAM and counters unchanged; flags persist 10 cycles and clear only on rst.
- Store to addr 2 issued during CLEAR -> err_store=1; after busy falls, addr 2 reads 0. Assert rst mid-clear at ptr=7 -> clear restarts and busy lasts the full 16 cycles after release.
- Preload load_count to 0xFFFFFFFE (force) and issue 3 in-range loads -> count reaches 0xFFFFFFFF and stays there.
